// File: rtl/word_nbyte_uart_rx_pkg.sv
// Shared types and constants for the tagged-byte word assembler.
package word_nbyte_uart_rx_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EXP_DATA = 2'd1,
      EXP_TAG  = 2'd2,
      EXP_CMD  = 2'd3
   } rx_state_e;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_SEQ     = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_OVERRUN = 2'b11;

   localparam logic [7:0] TAG_CMD   = 8'h00;
   localparam logic [7:0] TAG_FIRST = 8'h01;

   typedef struct packed {
      logic       vld;
      logic [1:0] code;
   } err_req_t;

   // Collapse the error sources into one report, timeout first, overrun last.
   function automatic err_req_t pick_err(input logic to, input logic seq, input logic ovr);
      err_req_t r;
      r.vld = to | seq | ovr;
      if (to)       r.code = ERR_TIMEOUT;
      else if (seq) r.code = ERR_SEQ;
      else if (ovr) r.code = ERR_OVERRUN;
      else          r.code = ERR_NONE;
      return r;
   endfunction

endpackage

// File: rtl/word_nbyte_uart_rx_timeout.sv
// Idle-cycle counter for inter-byte gaps inside a frame; saturates at the limit.
module frame_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] cnt;

   // Count enabled cycles, hold at the limit until cleared.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                        cnt <= '0;
      else if (clear)                    cnt <= '0;
      else if (enable && cnt != LIMIT)   cnt <= cnt + CW'(1);
   end

   assign expired = (cnt == LIMIT);
endmodule

// File: rtl/word_nbyte_uart_rx.sv
// Assembles tag/data byte pairs into a little-endian word, or a tag-0 command
// byte into a zero-extended command word, with sequence/timeout/overrun errors.
module word_nbyte_uart_rx
   import word_nbyte_uart_rx_pkg::*;
#(
   parameter int unsigned WORD_BYTES     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              byte_in,
   input  logic                    byte_valid,
   output logic [8*WORD_BYTES-1:0] word_data,
   output logic                    word_is_cmd,
   output logic                    word_valid,
   input  logic                    word_ready,
   output logic                    err_valid,
   output logic [1:0]              err_code
);
   localparam int unsigned WW = 8 * WORD_BYTES;

   rx_state_e     state, state_nx;
   logic [3:0]    k;
   logic [WW-1:0] shadow, shadow_fill, new_word;
   logic          new_is_cmd, complete, seq_err, timeout, ovr_err;
   logic          expired, accept, tag_ok, last_byte;
   err_req_t      err_nx;

   assign accept    = word_valid && word_ready;
   assign tag_ok    = (byte_in == ({4'd0, k} + 8'd1));
   assign last_byte = (k == 4'(WORD_BYTES));
   assign ovr_err   = complete && word_valid && !word_ready;
   assign err_nx    = pick_err(timeout, seq_err, ovr_err);

   frame_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (byte_valid || state == IDLE || timeout),
      .enable  (state != IDLE),
      .expired (expired)
   );

   // Shadow word with the incoming byte merged into lane k.
   always_comb begin
      shadow_fill = shadow;
      for (int i = 0; i < int'(WORD_BYTES); i++)
         if (k == 4'(i + 1)) shadow_fill[8*i +: 8] = byte_in;
   end

   // Frame parser: next state and completion/error strobes. A byte on the
   // expiry cycle is processed normally, so timeout only fires without one.
   always_comb begin
      state_nx   = state;
      complete   = 1'b0;
      seq_err    = 1'b0;
      timeout    = 1'b0;
      new_word   = shadow_fill;
      new_is_cmd = 1'b0;
      if (byte_valid) begin
         case (state)
            IDLE: begin
               if (byte_in == TAG_FIRST)    state_nx = EXP_DATA;
               else if (byte_in == TAG_CMD) state_nx = EXP_CMD;
            end
            EXP_DATA: begin
               if (last_byte) begin
                  complete = 1'b1;
                  state_nx = IDLE;
               end else begin
                  state_nx = EXP_TAG;
               end
            end
            EXP_TAG: begin
               if (tag_ok) state_nx = EXP_DATA;
               else begin
                  seq_err  = 1'b1;
                  state_nx = IDLE;
               end
            end
            EXP_CMD: begin
               complete   = 1'b1;
               new_is_cmd = 1'b1;
               new_word   = WW'(byte_in);
               state_nx   = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end else if (state != IDLE && expired) begin
         timeout  = 1'b1;
         state_nx = IDLE;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Byte index and shadow word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         k      <= '0;
         shadow <= '0;
      end else if (byte_valid) begin
         case (state)
            IDLE: if (byte_in == TAG_FIRST) begin
               k      <= 4'd1;
               shadow <= '0;
            end
            EXP_DATA: shadow <= shadow_fill;
            EXP_TAG: begin
               if (tag_ok) k      <= k + 4'd1;
               else        shadow <= '0;
            end
            default: ;
         endcase
      end
   end

   // Output word holding register and registered error report.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word_data   <= '0;
         word_is_cmd <= 1'b0;
         word_valid  <= 1'b0;
         err_valid   <= 1'b0;
         err_code    <= ERR_NONE;
      end else begin
         if (complete && !ovr_err) begin
            word_data   <= new_word;
            word_is_cmd <= new_is_cmd;
            word_valid  <= 1'b1;
         end else if (accept) begin
            word_valid  <= 1'b0;
         end
         err_valid <= err_nx.vld;
         if (err_nx.vld) err_code <= err_nx.code;
      end
   end
endmodule

// File: tb/tb_word_nbyte_uart_rx.sv
// Randomized + directed bench with a frame-level reference model and scoreboard.
`timescale 1ns/1ps
module tb_word_nbyte_uart_rx;
   localparam int WB = 4;
   localparam int TO = 16;
   localparam int WW = 8 * WB;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    byte_in = 8'h00;
   logic          byte_valid = 1'b0;
   logic          word_ready = 1'b0;
   logic [WW-1:0] word_data;
   logic          word_is_cmd, word_valid, err_valid;
   logic [1:0]    err_code;

   word_nbyte_uart_rx #(.WORD_BYTES(WB), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
      .word_data(word_data), .word_is_cmd(word_is_cmd), .word_valid(word_valid),
      .word_ready(word_ready), .err_valid(err_valid), .err_code(err_code)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   typedef struct {
      bit            is_err;
      logic [1:0]    code;
      logic [WW-1:0] data;
      bit            cmd;
      int            at;
   } ev_t;
   ev_t sb[$];

   // Reference model: frame-level parser state.
   bit         m_in_frame = 0, m_want_data = 0, m_is_cmd = 0, m_full = 0;
   logic [7:0] m_got[$];
   int         m_idle = 0;
   logic [1:0] m_code = 2'b00;
   int         rdy_pct = 50;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic void push_ev(bit e, logic [1:0] c, logic [WW-1:0] d, bit cmd, int at);
      ev_t x;
      x.is_err = e; x.code = c; x.data = d; x.cmd = cmd; x.at = at;
      sb.push_back(x);
   endfunction

   // One clock of stimulus; the model predicts what the coming edge produces.
   task automatic step(input bit bv, input logic [7:0] b, input bit rdy);
      int at;
      bit done;
      logic [WW-1:0] w;
      @(negedge clk);
      byte_valid = bv;
      byte_in    = bv ? b : 8'($urandom);
      word_ready = rdy;
      at   = cyc + 1;
      done = 0;
      if (!bv) begin
         if (m_in_frame) begin
            if (m_idle == TO) begin
               m_in_frame = 0; m_idle = 0; m_code = 2'b10;
               push_ev(1, 2'b10, '0, 0, at);
            end else m_idle++;
         end
      end else begin
         m_idle = 0;
         if (!m_in_frame) begin
            if (b == 8'h01 || b == 8'h00) begin
               m_in_frame = 1; m_want_data = 1; m_is_cmd = (b == 8'h00); m_got.delete();
            end
         end else if (m_want_data) begin
            m_got.push_back(b);
            if (m_is_cmd || m_got.size() == WB) begin done = 1; m_in_frame = 0; end
            else m_want_data = 0;
         end else if (int'(b) == m_got.size() + 1) begin
            m_want_data = 1;
         end else begin
            m_in_frame = 0; m_code = 2'b01;
            push_ev(1, 2'b01, '0, 0, at);
         end
      end
      if (done) begin
         w = '0;
         foreach (m_got[i]) w |= WW'(m_got[i]) << (8 * i);
         if (m_full && !rdy) begin
            m_code = 2'b11;
            push_ev(1, 2'b11, '0, 0, at);
         end else begin
            push_ev(0, 2'b00, w, m_is_cmd, at);
            m_full = 1;
         end
      end else if (m_full && rdy) begin
         m_full = 0;
      end
   endtask

   task automatic send(input logic [7:0] b, input bit rdy);
      step(1, b, rdy);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(0, 8'h00, rdy);
   endtask

   function automatic bit rrdy();
      return $urandom_range(0, 99) < rdy_pct;
   endfunction

   task automatic send_r(input logic [7:0] b);
      int gap;
      step(1, b, rrdy());
      gap = ($urandom_range(0, 11) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 2);
      for (int i = 0; i < gap; i++) step(0, 8'h00, rrdy());
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_word_data"}, word_data, 0);
      chk({tag, "_word_is_cmd"}, word_is_cmd, 0);
      chk({tag, "_word_valid"}, word_valid, 0);
      chk({tag, "_err_valid"}, err_valid, 0);
      chk({tag, "_err_code"}, err_code, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      byte_valid = 0; word_ready = 0;
      #2 reset = 0;
      m_in_frame = 0; m_full = 0; m_code = 2'b00; m_idle = 0; sb.delete();
      #1 chk_zero("midreset");
      @(negedge clk);
      @(negedge clk);
      reset = 1;
   endtask

   // Monitor: per-cycle output checks and scoreboard pops.
   bit            prev_wv = 0;
   logic [WW-1:0] last_d = '0;
   bit            last_c = 0;
   initial begin
      ev_t x;
      bit  acc;
      forever begin
         @(posedge clk);
         #1;
         if (!reset) begin
            prev_wv = 0;
         end else begin
            while (sb.size() > 0 && sb[0].at < cyc) begin
               x = sb.pop_front();
               chk("event_missed_cycle", cyc, x.at);
            end
            chk("word_valid", word_valid, m_full);
            chk("err_code_held", err_code, m_code);
            acc = prev_wv && word_ready;
            if (err_valid) begin
               if (sb.size() == 0) chk("err_valid_spurious", err_valid, 0);
               else begin
                  x = sb.pop_front();
                  chk("err_kind", x.is_err, 1);
                  chk("err_code_pulse", err_code, x.code);
                  chk("err_cycle", cyc, x.at);
               end
            end
            if (word_valid && (!prev_wv || acc)) begin
               if (sb.size() == 0) chk("word_spurious", word_valid, 0);
               else begin
                  x = sb.pop_front();
                  chk("word_kind", x.is_err, 0);
                  chk("word_data", word_data, x.data);
                  chk("word_is_cmd", word_is_cmd, x.cmd);
                  chk("word_cycle", cyc, x.at);
               end
            end else if (word_valid) begin
               chk("word_data_stable", word_data, last_d);
               chk("word_is_cmd_stable", word_is_cmd, last_c);
            end
            prev_wv = word_valid;
            last_d  = word_data;
            last_c  = word_is_cmd;
         end
      end
   end

   initial begin
      int kind;
      logic [7:0] t;
      #1 reset = 0;
      #2 chk_zero("reset");
      repeat (3) @(negedge clk);
      reset = 1;

      // Little-endian data word, one-cycle latency.
      send(8'h01, 0); send(8'hEF, 0); send(8'h02, 0); send(8'hBE, 0);
      send(8'h03, 0); send(8'hAD, 0); send(8'h04, 0); send(8'hDE, 0);
      idle(3, 0); idle(1, 1); idle(2, 0);

      // Command word held under backpressure, released by ready.
      send(8'h00, 0); send(8'h5A, 0);
      idle(10, 0); idle(1, 1); idle(3, 0);

      // Bad tag then a clean frame.
      send(8'h01, 0); send(8'h11, 0); send(8'h03, 0); idle(2, 0);
      send(8'h01, 0); send(8'hAA, 0); send(8'h02, 0); send(8'hBB, 0);
      send(8'h03, 0); send(8'hCC, 0); send(8'h04, 0); send(8'hDD, 0);
      idle(1, 1); idle(2, 0);

      // Timeout, then a stray tag byte ignored.
      send(8'h01, 0); send(8'h11, 0); idle(20, 0);
      send(8'h02, 0); idle(3, 0);

      // Overrun drop, then completion coinciding with accept.
      send(8'h00, 0); send(8'h01, 0); idle(2, 0);
      send(8'h00, 0); send(8'h02, 0); idle(2, 0);
      send(8'h00, 0); send(8'h02, 1); idle(1, 1); idle(2, 0);

      // Reset mid-frame drops the partial word.
      send(8'h01, 0); send(8'h11, 0); send(8'h02, 0);
      do_reset();
      send(8'h03, 0); send(8'h22, 0); send(8'h04, 0); send(8'h33, 0);
      idle(5, 0);

      // Randomized frames with varying consumer readiness.
      for (int f = 0; f < 300; f++) begin
         if (f % 50 == 0) rdy_pct = $urandom_range(10, 100);
         kind = $urandom_range(0, 9);
         if (kind < 5) begin
            for (int i = 1; i <= WB; i++) begin
               t = 8'(i);
               if ($urandom_range(0, 19) == 0) t = 8'($urandom_range(0, 6));
               send_r(t);
               send_r(8'($urandom));
            end
         end else if (kind < 7) begin
            send_r(8'h00);
            send_r(8'($urandom));
         end else if (kind == 7) begin
            send_r(8'($urandom));
         end else if (kind == 8) begin
            send(8'h01, rrdy());
            send(8'($urandom), rrdy());
            for (int i = 0; i < $urandom_range(15, 19); i++) step(0, 8'h00, rrdy());
         end else begin
            for (int i = 0; i < $urandom_range(1, 4); i++) step(0, 8'h00, rrdy());
         end
      end

      idle(25, 1);
      idle(2, 0);
      chk("scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/word_nbyte_uart_rx.md
WORD_NBYTE_UART_RX -- requirements
Module: word_nbyte_uart_rx

Interface
REQ-001 The block SHALL have parameter WORD_BYTES, default 4, meaning number of data bytes per word (legal range 1..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning idle cycles allowed between bytes inside a frame (legal range 2..2^24).
REQ-003 The block SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port byte_in  input  8  received UART byte, valid only when byte_valid=1.
REQ-006 The block SHALL have port byte_valid  input  1  one-cycle strobe marking one new byte.
REQ-007 The block SHALL have port word_data  output  8*WORD_BYTES  assembled word or zero-extended command byte.
REQ-008 The block SHALL have port word_is_cmd  output  1  word_data holds a command (1) or a data word (0).
REQ-009 The block SHALL have port word_valid  output  1  word_data/word_is_cmd valid; held until accepted.
REQ-010 The block SHALL have port word_ready  input  1  consumer accepts the word on a cycle where word_valid=1.
REQ-011 The block SHALL have port err_valid  output  1  one-cycle error pulse.
REQ-012 The block SHALL have port err_code  output  2  01 sequence, 10 timeout, 11 overrun; held from the pulse until the next error.

Function
REQ-013 Framing SHALL be: tag byte k (1..WORD_BYTES) followed by data byte k; tag 0x00 followed by one command byte.
REQ-014 The FSM SHALL have states IDLE, EXP_DATA, EXP_TAG and EXP_CMD, and SHALL advance only on byte_valid (timeout excepted).
REQ-015 In IDLE, tag 0x01 SHALL clear the shadow word, set index k=1 and go to EXP_DATA; tag 0x00 SHALL go to EXP_CMD; any other byte SHALL be ignored without error.
REQ-016 In EXP_DATA, the byte SHALL be written to shadow bits [8k-1:8k-8] (little-endian); if k==WORD_BYTES the word completes, otherwise the FSM goes to EXP_TAG.
REQ-017 In EXP_TAG, byte == k+1 SHALL increment k and go to EXP_DATA; any other value SHALL pulse err 01, discard the shadow word and go to IDLE, with that byte consumed.
REQ-018 In EXP_CMD, the byte SHALL complete a command word, zero-extended, with word_is_cmd=1, then go to IDLE.
REQ-019 On completion, word_valid SHALL assert on the cycle after the final byte_valid (latency 1) and the FSM SHALL return to IDLE.
REQ-020 word_data and word_is_cmd SHALL remain stable while word_valid=1; word_valid SHALL deassert the cycle after word_valid && word_ready.
REQ-021 A completion while word_valid=1 and word_ready=0 SHALL drop the new word, keep the old word and pulse err 11.
REQ-022 A completion in the same cycle as word_valid && word_ready SHALL load the new word with word_valid staying 1 and SHALL raise no error.
REQ-023 Outside IDLE, TIMEOUT_CYCLES consecutive cycles without byte_valid SHALL force IDLE and pulse err 10 on the following cycle.
REQ-024 The timeout counter SHALL clear on every byte_valid and while in IDLE; if byte_valid arrives on the expiry cycle, the byte SHALL win.
REQ-025 err_valid SHALL be registered, one cycle wide, and SHALL report at most one error per cycle with priority timeout > sequence > overrun.

Reset
REQ-026 Asserting reset SHALL immediately set the FSM to IDLE and clear k, the timeout counter, the shadow word, word_data, word_is_cmd, word_valid, err_valid and err_code.
REQ-027 Reset asserted mid-frame SHALL discard the partial word; after deassertion, bytes other than tags 0x00/0x01 SHALL be ignored.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the err_code constants and the command-tag constant 0x00.
REQ-029 The timeout counter SHALL be the single sub-module frame_timeout_counter, with inputs clear and enable and output expired.
REQ-030 The byte receiver (uart_sm_rx) SHALL be instantiated by the parent, not inside this block.

Verification
REQ-031 The bench SHALL cover: with WORD_BYTES=4, bytes 01 EF 02 BE 03 AD 04 DE -> word_data=0xDEADBEEF, word_is_cmd=0, word_valid 1 cycle after the last strobe.
REQ-032 The bench SHALL cover: bytes 00 5A -> word_data=0x0000005A, word_is_cmd=1; held with word_ready=0 for 10 cycles, dropped the cycle after word_ready=1.
REQ-033 The bench SHALL cover: bytes 01 11 03 -> err_code=01 pulse, no word; then 01 AA 02 BB 03 CC 04 DD -> 0xDDCCBBAA.
REQ-034 The bench SHALL cover: with TIMEOUT_CYCLES=16, bytes 01 11 then silence -> err_code=10 pulse 17 cycles after the last strobe; a later byte 02 is ignored.
REQ-035 The bench SHALL cover: with word_ready=0, frames 00 01 then 00 02 -> word_data stays 0x01 and err_code=11; repeated with word_ready=1 on the completion cycle -> 0x02 and no error.
REQ-036 The bench SHALL cover: reset asserted after 01 11 02 -> outputs zero at once; after release, 03 22 04 33 -> no word, no error.
